// File: rtl/mmc1_bus_monitor.sv
// Passive observer of the MMC1 serial register port: decodes the 5-write
// LSB-first protocol and keeps shadow copies of CTRL, CHR0, CHR1 and PRG.
module mmc1_bus_monitor #(
  parameter logic [4:0] CTRL_RESET    = 5'h0C,
  parameter int         IGNORE_CONSEC = 1,
  parameter int         CNT_W         = 16
) (
  input  logic             CLK,
  input  logic             nRES,
  input  logic             nROMSEL,
  input  logic             CPU_RnW,
  input  logic             CPU_D0,
  input  logic             CPU_D7,
  input  logic             CPU_A13,
  input  logic             CPU_A14,
  output logic             wr_valid,
  output logic [1:0]       wr_reg,
  output logic [4:0]       wr_data,
  output logic             rst_seen,
  output logic [2:0]       shift_cnt,
  output logic [4:0]       ctrl_q,
  output logic [4:0]       chr0_q,
  output logic [4:0]       chr1_q,
  output logic [4:0]       prg_q,
  output logic [CNT_W-1:0] wr_count
);

  localparam logic IGNORE_EN = (IGNORE_CONSEC != 0);

  logic       prev_wr;
  logic [3:0] shift_reg;
  logic       raw_wr;
  logic       qual_wr;
  logic [1:0] index;
  logic [4:0] value;

  // Only four bits need storing: the fifth arrives on the bus with the commit.
  assign raw_wr  = !nROMSEL && !CPU_RnW;
  assign qual_wr = raw_wr && !(IGNORE_EN && prev_wr);
  assign index   = {CPU_A14, CPU_A13};
  assign value   = {CPU_D0, shift_reg};

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      prev_wr   <= 1'b0;
      shift_reg <= '0;
      shift_cnt <= '0;
      wr_valid  <= 1'b0;
      rst_seen  <= 1'b0;
      wr_reg    <= '0;
      wr_data   <= '0;
      ctrl_q    <= CTRL_RESET;
      chr0_q    <= '0;
      chr1_q    <= '0;
      prg_q     <= '0;
      wr_count  <= '0;
    end else begin
      prev_wr  <= raw_wr;
      wr_valid <= 1'b0;
      rst_seen <= 1'b0;
      if (qual_wr) begin
        if (CPU_D7) begin
          shift_reg <= '0;
          shift_cnt <= '0;
          ctrl_q    <= ctrl_q | CTRL_RESET;
          rst_seen  <= 1'b1;
        end else if (shift_cnt == 3'd4) begin
          // Fifth bit: commit to the register addressed by this write only.
          shift_reg <= '0;
          shift_cnt <= '0;
          wr_valid  <= 1'b1;
          wr_reg    <= index;
          wr_data   <= value;
          wr_count  <= wr_count + CNT_W'(1);
          case (index)
            2'd0:    ctrl_q <= value;
            2'd1:    chr0_q <= value;
            2'd2:    chr1_q <= value;
            default: prg_q  <= value;
          endcase
        end else begin
          shift_reg <= {CPU_D0, shift_reg[3:1]};
          shift_cnt <= shift_cnt + 3'd1;
        end
      end
    end
  end

endmodule
